// File: rtl/apb_slave_pkg.sv
// Shared types and constants for the APB3 register-memory completer.
package apb_slave_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  typedef enum logic {OK, SLVERR} err_e;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned WORD_SHIFT = $clog2(WORD_BYTES);

  // Word-index width; a single-word memory still needs one address bit.
  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/apb_slave_regfile.sv
// DEPTH x DATA_W word memory: async clear, one synchronous write port, one combinational read port.
module apb_slave_regfile
  import apb_slave_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned IDX_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata = mem[raddr];
  end

endmodule

// File: rtl/apb_slave_mem.sv
// APB3 completer over a word-addressed register memory with a configurable number of wait states.
module apb_slave_mem
  import apb_slave_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       DEPTH       = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int unsigned       WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              PRESETn,
  input  logic              PSEL1,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR
);

  localparam int unsigned IDX_W = idx_width(DEPTH);
  localparam logic [3:0]  WS_CNT = 4'(WAIT_STATES);

  state_e             state, state_nxt;
  logic [3:0]         cnt, cnt_nxt;
  logic [IDX_W-1:0]   lat_idx, lat_idx_nxt;
  logic               lat_write, lat_write_nxt;
  logic [DATA_W-1:0]  lat_wdata, lat_wdata_nxt;
  err_e               lat_err, lat_err_nxt;
  logic               ready_nxt, slverr_nxt;
  logic [DATA_W-1:0]  rdata_nxt;

  logic [ADDR_W-1:0]  offset, word;
  err_e               cur_err;
  logic [IDX_W-1:0]   cur_idx;
  logic [IDX_W-1:0]   rd_idx;
  logic [DATA_W-1:0]  rd_data;
  logic               we;

  // Decode of the live bus address; only consumed in the setup cycle.
  always_comb begin
    offset  = PADDR - BASE_ADDR;
    word    = offset >> WORD_SHIFT;
    cur_err = ((PADDR < BASE_ADDR) || (word >= ADDR_W'(DEPTH)) ||
               (PADDR[WORD_SHIFT-1:0] != '0)) ? SLVERR : OK;
    cur_idx = word[IDX_W-1:0];
  end

  always_ff @(posedge clk or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_idx   <= '0;
      lat_write <= 1'b0;
      lat_wdata <= '0;
      lat_err   <= OK;
      PREADY    <= 1'b0;
      PSLVERR   <= 1'b0;
      PRDATA    <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      lat_idx   <= lat_idx_nxt;
      lat_write <= lat_write_nxt;
      lat_wdata <= lat_wdata_nxt;
      lat_err   <= lat_err_nxt;
      PREADY    <= ready_nxt;
      PSLVERR   <= slverr_nxt;
      PRDATA    <= rdata_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    lat_idx_nxt   = lat_idx;
    lat_write_nxt = lat_write;
    lat_wdata_nxt = lat_wdata;
    lat_err_nxt   = lat_err;
    ready_nxt     = 1'b0;
    slverr_nxt    = 1'b0;
    rdata_nxt     = '0;
    we            = 1'b0;
    rd_idx        = lat_idx;

    unique case (state)
      IDLE: begin
        // With zero wait states the response is formed straight from the setup-cycle decode.
        rd_idx = cur_idx;
        if (PSEL1 && !PENABLE) begin
          lat_idx_nxt   = cur_idx;
          lat_write_nxt = PWRITE;
          lat_wdata_nxt = PWDATA;
          lat_err_nxt   = cur_err;
          cnt_nxt       = WS_CNT;
          if (WS_CNT == 4'd0) begin
            state_nxt  = DONE;
            ready_nxt  = 1'b1;
            slverr_nxt = (cur_err == SLVERR);
            rdata_nxt  = (!PWRITE && cur_err == OK) ? rd_data : '0;
          end else begin
            state_nxt = ACCESS;
          end
        end
      end

      ACCESS: begin
        if (PSEL1 && PENABLE) begin
          if (cnt == 4'd1) begin
            state_nxt  = DONE;
            cnt_nxt    = '0;
            ready_nxt  = 1'b1;
            slverr_nxt = (lat_err == SLVERR);
            rdata_nxt  = (!lat_write && lat_err == OK) ? rd_data : '0;
          end else begin
            cnt_nxt = cnt - 4'd1;
          end
        end else begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end

      DONE: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        we        = PSEL1 && PENABLE && lat_write && (lat_err == OK);
      end

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  apb_slave_regfile #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_regfile (
    .clk   (clk),
    .rst_n (PRESETn),
    .we    (we),
    .waddr (lat_idx),
    .wdata (lat_wdata),
    .raddr (rd_idx),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_apb_slave_mem.sv
// Scoreboard bench: two completers (0 and 3 wait states) driven with directed and random APB traffic.
module tb_apb_slave_mem;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn    [2];
  logic        psel    [2];
  logic        penable [2];
  logic        pwrite  [2];
  logic [31:0] paddr   [2];
  logic [31:0] pwdata  [2];
  logic [31:0] prdata  [2];
  logic        pready  [2];
  logic        pslverr [2];

  apb_slave_mem #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(16), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(0)
  ) u_ws0 (
    .clk(clk), .PRESETn(rstn[0]), .PSEL1(psel[0]), .PENABLE(penable[0]), .PWRITE(pwrite[0]),
    .PADDR(paddr[0]), .PWDATA(pwdata[0]), .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0])
  );

  apb_slave_mem #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(16), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(3)
  ) u_ws3 (
    .clk(clk), .PRESETn(rstn[1]), .PSEL1(psel[1]), .PENABLE(penable[1]), .PWRITE(pwrite[1]),
    .PADDR(paddr[1]), .PWDATA(pwdata[1]), .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1])
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] model [2][16];
  int          errors = 0;
  int          checks = 0;
  bit          prev_rdy [2];

  function automatic int wait_states(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Reference response from the address map: 16 words at 0x0, word aligned.
  function automatic exp_t ref_resp(input int d, input bit wr, input logic [31:0] addr);
    exp_t e;
    e.err  = (addr[1:0] != 2'b00) || ((addr / 4) >= 16);
    e.data = (!wr && !e.err) ? model[d][addr[5:2]] : 32'h0;
    return e;
  endfunction

  function automatic void push(input int d, input exp_t e);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endfunction

  task automatic mon(input int d);
    exp_t e;
    bit   have;
    if (rstn[d]) begin
      if (pready[d]) begin
        check("pready_single_cycle", {31'b0, prev_rdy[d]}, 32'h0);
        have = (d == 0) ? (q0.size() != 0) : (q1.size() != 0);
        if (!have) begin
          fail_now("unexpected_pready");
        end else begin
          e = (d == 0) ? q0.pop_front() : q1.pop_front();
          check("pslverr", {31'b0, pslverr[d]}, {31'b0, e.err});
          check("prdata", prdata[d], e.data);
        end
      end else begin
        check("idle_prdata", prdata[d], 32'h0);
        check("idle_pslverr", {31'b0, pslverr[d]}, 32'h0);
      end
      prev_rdy[d] = pready[d];
    end else begin
      prev_rdy[d] = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) mon(d);
  end

  task automatic setup(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] data);
    psel[d]    = 1'b1;
    penable[d] = 1'b0;
    pwrite[d]  = wr;
    paddr[d]   = addr;
    pwdata[d]  = data;
    @(posedge clk); #1;
    penable[d] = 1'b1;
    // Bus values are irrelevant after setup; scramble them.
    pwrite[d]  = 1'($urandom);
    paddr[d]   = $urandom;
    pwdata[d]  = $urandom;
  endtask

  // Leaves PSEL high so the caller can chain a back-to-back transfer.
  task automatic xfer(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] data);
    exp_t e;
    int   n;
    bit   rdy;
    e = ref_resp(d, wr, addr);
    push(d, e);
    setup(d, wr, addr, data);
    n   = 0;
    rdy = 1'b0;
    while (!rdy && n < 40) begin
      n++;
      @(negedge clk);
      rdy = pready[d];
      @(posedge clk); #1;
    end
    if (!rdy) fail_now("pready_timeout");
    else      check("access_cycles", n, wait_states(d) + 1);
    if (rdy && wr && !e.err) model[d][addr[5:2]] = data;
    penable[d] = 1'b0;
  endtask

  task automatic idle(input int d, input int n);
    psel[d]    = 1'b0;
    penable[d] = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic read_all(input int d);
    for (int unsigned a = 0; a < 16; a++) begin
      xfer(d, 1'b0, a * 4, 32'h0);
      idle(d, 1);
    end
  endtask

  task automatic abort_xfer(input int d, input bit drop_sel_first, input logic [31:0] addr,
                            input logic [31:0] data);
    setup(d, 1'b1, addr, data);
    @(posedge clk); #1;
    if (drop_sel_first) begin
      psel[d]    = 1'b0;
      penable[d] = 1'b0;
    end else begin
      penable[d] = 1'b0;
      @(posedge clk); #1;
      psel[d]    = 1'b0;
    end
    idle(d, 6);
  endtask

  task automatic reset_mid_transfer(input int d);
    int n;
    bit rdy;
    push(d, ref_resp(d, 1'b1, 32'h18));
    setup(d, 1'b1, 32'h18, 32'h77);
    n   = 0;
    rdy = 1'b0;
    while (!rdy && n < 40) begin
      n++;
      @(negedge clk);
      rdy = pready[d];
      if (!rdy) begin
        @(posedge clk); #1;
      end
    end
    if (!rdy) fail_now("reset_pready_timeout");
    // Reset lands inside the completing cycle, before the committing edge.
    #2;
    rstn[d] = 1'b0;
    #1;
    check("rst_pready", {31'b0, pready[d]}, 32'h0);
    check("rst_pslverr", {31'b0, pslverr[d]}, 32'h0);
    check("rst_prdata", prdata[d], 32'h0);
    psel[d]    = 1'b0;
    penable[d] = 1'b0;
    @(posedge clk); #1;
    rstn[d] = 1'b1;
    for (int i = 0; i < 16; i++) model[d][i] = 32'h0;
    idle(d, 1);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] v;
    int          r;
    for (int d = 0; d < 2; d++) begin
      rstn[d] = 1'b0; psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
      paddr[d] = '0; pwdata[d] = '0; prev_rdy[d] = 1'b0;
      for (int i = 0; i < 16; i++) model[d][i] = 32'h0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("reset_prdata", prdata[d], 32'h0);
      check("reset_pready", {31'b0, pready[d]}, 32'h0);
      check("reset_pslverr", {31'b0, pslverr[d]}, 32'h0);
    end
    rstn[0] = 1'b1;
    rstn[1] = 1'b1;
    @(posedge clk); #1;

    xfer(0, 1'b1, 32'h4, 32'hDEAD_BEEF); idle(0, 1);
    xfer(0, 1'b0, 32'h4, 32'h0);         idle(0, 1);
    xfer(1, 1'b0, 32'h0, 32'h0);         idle(1, 1);

    for (int d = 0; d < 2; d++) begin
      xfer(d, 1'b1, 32'h40, 32'h1234_5678); idle(d, 1);
      xfer(d, 1'b1, 32'h6, 32'h8765_4321);  idle(d, 1);
      read_all(d);
      xfer(d, 1'b1, 32'h8, 32'h1);
      xfer(d, 1'b1, 32'hC, 32'h2);
      xfer(d, 1'b0, 32'h8, 32'h0);
      xfer(d, 1'b0, 32'hC, 32'h0);
      idle(d, 1);
    end

    abort_xfer(1, 1'b1, 32'h10, 32'h55);
    xfer(1, 1'b0, 32'h10, 32'h0); idle(1, 1);
    abort_xfer(1, 1'b0, 32'h10, 32'h66);
    xfer(1, 1'b0, 32'h10, 32'h0); idle(1, 1);

    xfer(1, 1'b1, 32'h14, 32'hA5); idle(1, 1);
    xfer(1, 1'b0, 32'h14, 32'h0);  idle(1, 1);
    reset_mid_transfer(1);
    xfer(1, 1'b0, 32'h14, 32'h0);  idle(1, 1);
    xfer(1, 1'b0, 32'h18, 32'h0);  idle(1, 1);

    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 60; k++) begin
        r = int'($urandom_range(0, 9));
        if (r == 0)      a = $urandom_range(16, 20) * 4;
        else if (r == 1) a = $urandom_range(0, 15) * 4 + $urandom_range(1, 3);
        else             a = $urandom_range(0, 15) * 4;
        v = $urandom;
        xfer(d, 1'($urandom), a, v);
        if ($urandom_range(0, 1) == 1) idle(d, int'($urandom_range(1, 2)));
      end
      idle(d, 1);
      read_all(d);
    end

    idle(0, 4);
    idle(1, 4);
    check("scoreboard_drained", q0.size() + q1.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "simulation time limit");
  end

endmodule
